// File: rtl/vga_timing_gen.sv
//=============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator. Free-running horizontal
//            and vertical counters, advanced by a pixel clock-enable, are
//            decoded into registered sync, data-enable, coordinate and
//            line/frame strobe outputs. Every output is delayed one ce-tick
//            from the counter value it was decoded from, so all outputs stay
//            mutually aligned.
// Ports    : clk         - system clock
//            clr         - asynchronous active-high reset
//            ce          - pixel clock-enable; all state advances only when high
//            hsync/vsync - sync outputs, asserted level set by *_SYNC_POL
//            de          - high inside the visible area
//            x/y         - pixel column/row of the current output cycle
//            line_start  - one-clk pulse on the first pixel of every line
//            frame_start - one-clk pulse on the first pixel of every frame
//            rgb         - {R4,G4,B4} colour-bar test pattern
// Options  : VGA_TEST_PATTERN_EN - when defined, rgb carries eight vertical
//            colour bars; otherwise rgb is tied to zero.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int CW         = 12
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ce,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [11:0]   rgb
);

   localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] C_H_LAST     = CW'(C_H_TOTAL - 1);
   localparam logic [CW-1:0] C_V_LAST     = CW'(C_V_TOTAL - 1);
   localparam logic [CW-1:0] C_H_ACT      = CW'(H_ACTIVE);
   localparam logic [CW-1:0] C_V_ACT      = CW'(V_ACTIVE);
   localparam logic [CW-1:0] C_HS_FIRST   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] C_HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] C_VS_FIRST   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] C_VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] C_ONE        = CW'(1);
   localparam logic          C_HPOL       = (H_SYNC_POL != 0);
   localparam logic          C_VPOL       = (V_SYNC_POL != 0);

   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [CW-1:0] x_q, y_q;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          h_wrap, v_wrap;

   //------------------------------------------------------------------------
   // Counter next-state and output decode. The decode looks at the current
   // counter values; the registers below capture it on the ce edge, which
   // gives the one ce-tick latency shared by every output.
   //------------------------------------------------------------------------
   always_comb begin
      h_wrap = (hcnt_q == C_H_LAST);
      v_wrap = (vcnt_q == C_V_LAST);
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (ce) begin
         hcnt_d = h_wrap ? '0 : hcnt_q + C_ONE;
         // Vertical only steps on the last pixel of a line, so a combined
         // wrap takes both counters to zero on the same edge.
         if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + C_ONE;
         end
      end

      hsync_d = ((hcnt_q >= C_HS_FIRST) && (hcnt_q <= C_HS_LAST)) ? C_HPOL : ~C_HPOL;
      vsync_d = ((vcnt_q >= C_VS_FIRST) && (vcnt_q <= C_VS_LAST)) ? C_VPOL : ~C_VPOL;
      de_d    = (hcnt_q < C_H_ACT) && (vcnt_q < C_V_ACT);

      // Strobes are qualified by ce so they last one clk even when ce is
      // sparse, and drop to zero on every non-ce clk.
      line_start_d  = ce && (hcnt_q == '0);
      frame_start_d = line_start_d && (vcnt_q == '0);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         hsync_q       <= ~C_HPOL;
         vsync_q       <= ~C_VPOL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         if (ce) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= hcnt_q;
            y_q     <= vcnt_q;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
   localparam int C_BAR_W = H_ACTIVE / 8;

   logic [2:0]  bar_idx;
   logic [11:0] rgb_d, rgb_q;

   always_comb begin
      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (hcnt_q >= CW'(i * C_BAR_W)) begin
            bar_idx = 3'(i);
         end
      end
      // Bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black:
      // R is the inverse of index bit 1, G of bit 2, B of bit 0.
      rgb_d = 12'h000;
      if (de_d) begin
         rgb_d = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rgb_q <= 12'h000;
      end else if (ce) begin
         rgb_q <= rgb_d;
      end
   end

   assign rgb = rgb_q;
`else
   assign rgb = 12'h000;
`endif

endmodule

`default_nettype wire
